// File: rtl/fb_arb_pkg.sv
// Shared defaults and fill-engine state encoding for the frame-buffer write arbiter.
package fb_arb_pkg;

  localparam int FB_ADDR_W    = 19;
  localparam int FB_DATA_W    = 8;
  localparam int FB_DEPTH_DEF = 307200;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fillState_e;

endpackage

// File: rtl/fb_fill_engine.sv
// Hardware rectangle/span fill engine: walks a linear address range writing one
// colour, yielding to the arbiter whenever its request is not granted.
module fb_fill_engine
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int DATA_W   = FB_DATA_W,
  parameter int FB_DEPTH = FB_DEPTH_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] len_i,
  input  logic [DATA_W-1:0] color_i,
  input  logic              abort_i,
  input  logic              grant_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FB_DEPTH - 1);

  fillState_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [DATA_W-1:0] color_q, color_d;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= FILL_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      color_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      color_q  <= color_d;
    end
  end

  // The last-address test stops the walk before the counter could wrap.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    color_d  = color_q;
    unique case (state_q)
      FILL_IDLE: begin
        if (start_i) begin
          addr_d   = base_i;
          remain_d = len_i;
          color_d  = color_i;
          if ((len_i == '0) || (base_i > LastAddr)) state_d = FILL_DONE;
          else                                      state_d = FILL_RUN;
        end
      end
      FILL_RUN: begin
        if (abort_i) begin
          state_d = FILL_DONE;
        end else if (grant_i) begin
          if (addr_q != LastAddr) addr_d = addr_q + ADDR_W'(1);
          if (remain_q != '0)     remain_d = remain_q - ADDR_W'(1);
          if ((remain_q <= ADDR_W'(1)) || (addr_q == LastAddr)) state_d = FILL_DONE;
        end
      end
      FILL_DONE: state_d = FILL_IDLE;
      default:   state_d = FILL_IDLE;
    endcase
  end

  assign req_o  = (state_q == FILL_RUN) && !abort_i;
  assign addr_o = addr_q;
  assign data_o = color_q;
  assign busy_o = (state_q == FILL_RUN);
  assign done_o = (state_q == FILL_DONE);

endmodule

// File: rtl/fb_write_arbiter.sv
// Single-port frame-buffer write arbiter: the processor always wins, the fill
// engine takes every slot the processor leaves free; all fb_* outputs registered.
module fb_write_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W   = FB_ADDR_W,
  parameter int DATA_W   = FB_DATA_W,
  parameter int FB_DEPTH = FB_DEPTH_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W-1:0] fill_len,
  input  logic [DATA_W-1:0] fill_color,
  input  logic              fill_abort,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              fb_wren,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FB_DEPTH - 1);

  logic              cpuValid;
  logic              fillReq;
  logic              fillGrant;
  logic [ADDR_W-1:0] fillAddr;
  logic [DATA_W-1:0] fillData;

  logic              fbWren_q, fbWren_d;
  logic [ADDR_W-1:0] fbAddr_q, fbAddr_d;
  logic [DATA_W-1:0] fbData_q, fbData_d;

  fb_fill_engine #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .FB_DEPTH(FB_DEPTH)
  ) uFill (
    .clock  (clock),
    .resetn (resetn),
    .start_i(fill_start),
    .base_i (fill_base),
    .len_i  (fill_len),
    .color_i(fill_color),
    .abort_i(fill_abort),
    .grant_i(fillGrant),
    .req_o  (fillReq),
    .addr_o (fillAddr),
    .data_o (fillData),
    .busy_o (fill_busy),
    .done_o (fill_done)
  );

  // An out-of-range processor write is dropped and does not block the fill.
  assign cpuValid  = cpu_wren && (cpu_addr <= LastAddr);
  assign fillGrant = fillReq && !cpuValid;

  always_comb begin
    fbWren_d = 1'b0;
    fbAddr_d = fbAddr_q;
    fbData_d = fbData_q;
    if (cpuValid) begin
      fbWren_d = 1'b1;
      fbAddr_d = cpu_addr;
      fbData_d = cpu_data;
    end else if (fillGrant) begin
      fbWren_d = 1'b1;
      fbAddr_d = fillAddr;
      fbData_d = fillData;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fbWren_q <= 1'b0;
      fbAddr_q <= '0;
      fbData_q <= '0;
    end else begin
      fbWren_q <= fbWren_d;
      fbAddr_q <= fbAddr_d;
      fbData_q <= fbData_d;
    end
  end

  assign fb_wren = fbWren_q;
  assign fb_addr = fbAddr_q;
  assign fb_data = fbData_q;

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, frame-buffer address width.
REQ-002 SHALL have parameter DATA_W, default 8, pixel data width.
REQ-003 SHALL have parameter FB_DEPTH, default 307200, number of valid pixel addresses (640x480).
REQ-004 SHALL have port clock  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port cpu_wren  input  1  processor write request, one write per asserted cycle, no backpressure.
REQ-007 SHALL have port cpu_addr  input  ADDR_W  processor write address.
REQ-008 SHALL have port cpu_data  input  DATA_W  processor write data.
REQ-009 SHALL have port fill_start  input  1  one-cycle pulse that requests a hardware fill.
REQ-010 SHALL have port fill_base  input  ADDR_W  fill start address, sampled with fill_start.
REQ-011 SHALL have port fill_len  input  ADDR_W  fill pixel count, sampled with fill_start.
REQ-012 SHALL have port fill_color  input  DATA_W  fill pixel value, sampled with fill_start.
REQ-013 SHALL have port fill_abort  input  1  terminates an active fill.
REQ-014 SHALL have port fill_busy  output  1  high while a fill is in progress (RUN).
REQ-015 SHALL have port fill_done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port fb_wren  output  1  registered write enable to the VGA frame buffer.
REQ-017 SHALL have port fb_addr  output  ADDR_W  registered frame-buffer write address.
REQ-018 SHALL have port fb_data  output  DATA_W  registered frame-buffer write data.

Function
REQ-019 SHALL register every frame-buffer write: a request granted in cycle N appears on fb_* in cycle N+1.
REQ-020 SHALL give the processor absolute priority; when a valid cpu_wren wins a cycle, the fill engine neither writes nor advances in that cycle.
REQ-021 SHALL drop a cpu_wren with cpu_addr >= FB_DEPTH, driving fb_wren low for that write, and SHALL leave that slot free for the fill engine.
REQ-022 SHALL implement the fill FSM with states IDLE, RUN and DONE.
REQ-023 In IDLE, fill_start SHALL latch base, len and color. The FSM SHALL enter RUN, or DONE directly if len==0 or base >= FB_DEPTH.
REQ-024 In RUN, each cycle without a CPU grant SHALL write color to the current address, then increment the address and decrement the remaining count.
REQ-025 RUN SHALL exit to DONE after the write that makes remaining 0, or after the write to address FB_DEPTH-1; no address wrap-around is permitted.
REQ-026 fill_abort asserted in RUN SHALL go to DONE next cycle, and no fill write SHALL be issued in the abort cycle.
REQ-027 DONE SHALL assert fill_done for exactly one cycle and return to IDLE.
REQ-028 fill_start outside IDLE SHALL be ignored, and fill_abort outside RUN SHALL be ignored.
REQ-029 fill_busy SHALL equal (state==RUN).
REQ-030 Remaining and address counters SHALL be ADDR_W bits, unsigned, and SHALL never underflow.

Reset
REQ-031 While resetn is low, the block SHALL force state IDLE; fb_wren, fill_busy and fill_done to 0; fb_addr, fb_data and all latched fill registers to 0.
REQ-032 Reset during RUN SHALL abandon the fill with no done pulse, and the first cycle after release SHALL issue no write.

Structure
REQ-033 Package fb_arb_pkg SHALL hold ADDR_W, DATA_W and FB_DEPTH defaults and the fill state encoding.
REQ-034 The fill FSM and counters SHALL be the sub-module fb_fill_engine, exposing req/addr/data/grant; arbitration and output registers SHALL remain in fb_write_arbiter.

Verification
REQ-035 Stimulus: cpu_wren with addr 0x00010 and data 0x3C, no fill active. Required response: the next cycle has fb_wren=1, fb_addr=0x00010, fb_data=0x3C.
REQ-036 Stimulus: fill base 100, len 4, color 0xFF, with cpu_wren on the 2nd RUN cycle to addr 5. Required response: fb writes 100, 5, 101, 102, 103 in order; fill_done pulses once; fill_busy stays high for 5 cycles.
REQ-037 Stimulus: fill base 307198, len 10. Required response: writes go only to 307198 and 307199, followed by fill_done.
REQ-038 Stimulus: fill len 0, then fill base 307200. Required response: each produces no fb_wren and a single fill_done pulse.
REQ-039 Stimulus: fill len 1000, abort on the 3rd RUN cycle, plus a second fill_start while busy. Required response: exactly 2 fill writes; the second start is ignored; one fill_done.
REQ-040 Stimulus: resetn low mid-fill. Required response: outputs are immediately 0; after release, no writes and no fill_done occur until a new fill_start.
